// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIF coprocessor result path: result record and
// per-ID commit status encoding.
package fir_xifu_pkg;

   localparam int unsigned XIF_ID_WIDTH = 4;

   typedef enum logic [1:0] {
      STATUS_PENDING   = 2'd0,
      STATUS_COMMITTED = 2'd1,
      STATUS_KILLED    = 2'd2
   } fir_xifu_status_e;

   typedef struct packed {
      logic [XIF_ID_WIDTH-1:0] id;
      logic [31:0]             data;
      logic [4:0]              rd;
      logic                    we;
      logic                    exc;
      logic [5:0]              exccode;
   } fir_xifu_result_t;

endpackage

// File: rtl/fir_xifu_commit_table.sv
// Per-ID commit/kill status table. Commits set an entry, head release/drop
// returns it to PENDING; the head's status is read combinationally.
module fir_xifu_commit_table
   import fir_xifu_pkg::*;
#(
   parameter int unsigned X_ID_WIDTH = XIF_ID_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  set_valid_i,
   input  logic [X_ID_WIDTH-1:0] set_id_i,
   input  logic                  set_kill_i,
   input  logic                  clr_valid_i,
   input  logic [X_ID_WIDTH-1:0] clr_id_i,
   input  logic [X_ID_WIDTH-1:0] rd_id_i,
   output fir_xifu_status_e      rd_status_o
);

   localparam int unsigned N_IDS = 2 ** X_ID_WIDTH;

   fir_xifu_status_e status_q [N_IDS];

   // Clear is applied after set so a release of the same ID takes priority.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < N_IDS; i++) begin
            status_q[i] <= STATUS_PENDING;
         end
      end else begin
         if (set_valid_i) begin
            status_q[set_id_i] <= set_kill_i ? STATUS_KILLED : STATUS_COMMITTED;
         end
         if (clr_valid_i) begin
            status_q[clr_id_i] <= STATUS_PENDING;
         end
      end
   end

   assign rd_status_o = status_q[rd_id_i];

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!rst_i && set_valid_i && clr_valid_i) begin
         assert (set_id_i != clr_id_i)
            else $error("commit_table: commit on id %0d while it is released", set_id_i);
      end
   end
`endif

endmodule

// File: rtl/fir_xifu_result_fifo.sv
// In-order result buffer for the XIF result channel: holds writeback results
// until their instruction is committed, silently drops killed ones.
module fir_xifu_result_fifo
   import fir_xifu_pkg::*;
#(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned X_ID_WIDTH = XIF_ID_WIDTH
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   input  logic                       push_valid_i,
   output logic                       push_ready_o,
   input  fir_xifu_result_t           push_result_i,
   input  logic                       commit_valid_i,
   input  logic [X_ID_WIDTH-1:0]      commit_id_i,
   input  logic                       commit_kill_i,
   output logic                       result_valid_o,
   input  logic                       result_ready_i,
   output fir_xifu_result_t           result_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   fir_xifu_result_t   mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               flush;
   logic               not_empty;
   logic               push_fire;
   logic               pop_fire;
   logic               drop_fire;
   logic               release_head;
   fir_xifu_result_t   head;
   fir_xifu_status_e   head_status;

   assign flush        = rst_i || clear_i;
   assign head         = mem[rd_ptr];
   assign not_empty    = (count != '0);
   assign push_ready_o = (count < CNT_W'(DEPTH));
   assign push_fire    = push_valid_i && push_ready_o;

   // Killed heads never reach the core; they are retired internally.
   assign result_valid_o = not_empty && (head_status == STATUS_COMMITTED);
   assign pop_fire       = result_valid_o && result_ready_i;
   assign drop_fire      = not_empty && (head_status == STATUS_KILLED);
   assign release_head   = pop_fire || drop_fire;

   assign result_o = not_empty ? head : '0;
   assign count_o  = count;

   fir_xifu_commit_table #(
      .X_ID_WIDTH (X_ID_WIDTH)
   ) u_commit_table (
      .clk_i       (clk_i),
      .rst_i       (flush),
      .set_valid_i (commit_valid_i),
      .set_id_i    (commit_id_i),
      .set_kill_i  (commit_kill_i),
      .clr_valid_i (release_head),
      .clr_id_i    (head.id),
      .rd_id_i     (head.id),
      .rd_status_o (head_status)
   );

   always_ff @(posedge clk_i) begin
      if (push_fire) begin
         mem[wr_ptr] <= push_result_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_fire) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (release_head) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push_fire) - CNT_W'(release_head);
      end
   end

`ifndef SYNTHESIS
   logic             dup_id;
   logic [PTR_W-1:0] slot;

   // The head leaving this cycle no longer counts as in flight.
   always_comb begin
      dup_id = 1'b0;
      slot   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         slot = rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < count) && !((i == 0) && release_head)
             && (mem[slot].id == push_result_i.id)) begin
            dup_id = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!flush && push_fire) begin
         assert (!dup_id)
            else $error("result_fifo: id %0d pushed while still in flight", push_result_i.id);
      end
   end
`endif

endmodule

// File: doc/fir_xifu_result_fifo.md
# fir_xifu_result_fifo

Result-return buffer between the FIR XIF coprocessor writeback stage and the core's XIF result channel. It queues writeback results in order and tracks per-ID commit/kill status from the commit interface. A result is released to the core only once its instruction is committed; killed instructions are dropped silently. It decouples writeback from `result_ready` back-pressure.

## Interface
Parameters:
- `DEPTH`, 2: number of result entries (power of two, ≥2).
- `X_ID_WIDTH`, 4: XIF instruction ID width; the status table has 2^X_ID_WIDTH slots.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clear_i`  in  1  synchronous flush, same effect as reset.
- `push_valid_i`  in  1  writeback offers a result.
- `push_ready_o`  out  1  buffer accepts it.
- `push_result_i`  in  `fir_xifu_result_t`  {id, data[31:0], rd[4:0], we, exc, exccode[5:0]}.
- `commit_valid_i`  in  1  XIF commit transaction.
- `commit_id_i`  in  X_ID_WIDTH  committed/killed ID.
- `commit_kill_i`  in  1  1 = kill, 0 = commit.
- `result_valid_o`  out  1  XIF result valid.
- `result_ready_i`  in  1  core accepts result.
- `result_o`  out  `fir_xifu_result_t`  head entry fields.
- `count_o`  out  $clog2(DEPTH)+1  occupancy, for debug and verification.

## Operation
- Circular FIFO: write pointer, read pointer, count. Push fires on `push_valid_i && push_ready_o`. `push_ready_o = (count < DEPTH)`.
- Status table: one 2-bit state per ID, PENDING/COMMITTED/KILLED.
  - On `commit_valid_i`, `status[commit_id_i]` becomes KILLED if `commit_kill_i`, else COMMITTED.
  - On head pop or head drop, `status[head.id]` returns to PENDING.
  - A commit for an ID not yet pushed is held in the table until that result arrives.
- Head handling, evaluated each cycle with count>0:
  - PENDING: `result_valid_o=0`; wait.
  - COMMITTED: `result_valid_o=1`; pop on `result_ready_i`.
  - KILLED: `result_valid_o=0`; drop the head internally in one cycle.
- Once `result_valid_o` rises, it and `result_o` stay stable until `result_ready_i`. This holds by construction, because a committed ID cannot later be killed.
- `result_o` shows the head entry whenever count>0, and '0 when empty.
- IDs in flight are unique. A duplicate push of an ID still in the FIFO is illegal and is flagged by a simulation assertion.

## Timing
- Reset or clear: pointers=0, count=0, all statuses PENDING, `result_valid_o=0`, `result_o='0`, `count_o=0`, `push_ready_o=1` from the following cycle.
- Latency:
  - Push with its ID already COMMITTED: `result_valid_o` rises 1 cycle later. There is no same-cycle bypass.
  - Commit arriving after the push: `result_valid_o` rises 1 cycle after the commit cycle.
- Throughput: one pop or drop per cycle. Push and pop in the same cycle are both allowed when not full; count is unchanged.
- Full: `push_ready_o=0` even if a pop occurs that cycle; there is no full-pass-through.
- Simultaneous events:
  - Commit on ID A and release/drop of head ID B in the same cycle both take effect.
  - If A==B, the release/drop clear wins. A==B is illegal because IDs are unique; a simulation assertion flags it.
- Pointer wrap-around at DEPTH-1 → 0.
- `clear_i` or `rst_i` mid-handshake: in-flight result lost; `result_valid_o` drops the next cycle regardless of `result_ready_i`.

## Structure
- `fir_xifu_pkg`: `fir_xifu_result_t` struct, `fir_xifu_status_e` enum (PENDING/COMMITTED/KILLED), X_ID_WIDTH default constant.
- Sub-module `fir_xifu_commit_table`: the status array, with set port (commit) and clear port (release/drop), plus combinational read of `status[head.id]`.
- FIFO storage, pointers and handshakes stay in the top module.

## Test plan
- Commit id=3 (kill=0) at cycle 0; push {id=3, data=0xDEADBEEF, rd=5, we=1} at cycle 2 with `result_ready_i=1` → `result_valid_o=1` at cycle 3 with those fields, popped the same cycle, count back to 0 at cycle 4.
- Push id=1 at cycle 0; commit id=1 at cycle 4 → `result_valid_o` stays 0 through cycle 4 and rises at cycle 5.
- Push id=1 and id=2; kill id=1, commit id=2 → id=1 never appears on the output; id=2 is presented one cycle after id=1 is dropped.
- DEPTH=2, `result_ready_i=0`, all IDs committed, three pushes → `push_ready_o=0` after the second push. `result_o` is stable for 10 cycles. One pop, then the third push is accepted the next cycle.
- Two entries queued, `result_valid_o=1`, `result_ready_i=0`; pulse `clear_i` → next cycle `result_valid_o=0`, `count_o=0`, statuses PENDING; a re-pushed id=3 waits for a fresh commit.
- Assert `rst_i` mid-stream with a wrap-around in progress → all outputs return to reset values; 8 subsequent push/commit/pop transactions come out in order with correct data.
